// File: rtl/vec_loader.sv
`default_nettype none
// ============================================================================
//  Module      : vec_loader
//  Description : Drains one vector of tokens from an input FIFO into the
//                shared vector RAM (addresses 0..len-1), then hands the
//                vector to the max stage with a start pulse and waits for
//                its done before accepting another vector.
//  Revision    : 1.0  initial release
// ============================================================================
module vec_loader #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16   // maximum vector length, must be <= 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] length_in,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             start_out,
  output logic [WIDTH-1:0] vec_len,
  input  logic             done_in,
  output logic             busy,
  output logic             load_done,
  output logic             len_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] c_depth = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] r_rd_cnt;
  logic [WIDTH-1:0] r_wr_cnt;
  logic             r_rd_valid;
  logic             r_start;
  logic             r_load_done;
  logic             r_len_err;
  logic             r_busy;

  logic             w_go_legal;
  logic             w_rd_en;
  logic             w_last_wr;

  // A length is legal when it is non-zero and fits the RAM.
  assign w_go_legal = (length_in != '0) && (length_in <= c_depth);

  // Pop only while loading, when data exists and the vector is not yet fully read.
  assign w_rd_en    = (r_state == S_LOAD) && !fifo_empty && (r_rd_cnt < r_len);

  // The write carrying the final token of the vector.
  assign w_last_wr  = r_rd_valid && (r_wr_cnt == r_len - c_one);

  assign fifo_rd_en  = w_rd_en;
  assign mem_wr_en   = r_rd_valid;
  assign mem_wr_addr = r_wr_cnt;
  assign mem_wr_data = fifo_data;
  assign start_out   = r_start;
  assign vec_len     = r_len;
  assign busy        = r_busy;
  assign load_done   = r_load_done;
  assign len_err     = r_len_err;

  // Control FSM, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_start     <= 1'b0;
      r_load_done <= 1'b0;
      r_len_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Pulses default low; the FIFO read data is valid one cycle after a pop.
      r_start     <= 1'b0;
      r_load_done <= 1'b0;
      r_len_err   <= 1'b0;
      r_rd_valid  <= w_rd_en;

      case (r_state)
        S_IDLE: begin
          if (go) begin
            if (w_go_legal) begin
              r_len    <= length_in;
              r_rd_cnt <= '0;
              r_wr_cnt <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_LOAD;
            end else begin
              r_len_err <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_rd_en) begin
            r_rd_cnt <= r_rd_cnt + c_one;
          end
          if (r_rd_valid) begin
            r_wr_cnt <= r_wr_cnt + c_one;
          end
          if (w_last_wr) begin
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (done_in) begin
            r_load_done <= 1'b1;
            r_state     <= S_FIN;
          end
        end

        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
